pulpino_spi_slave_rx: RTL
=========================

// Module: pulpino_spi_slave_rx
// PURPOSE
// - SPI responder (slave end) for the PULPino SPI master IP: decodes one CS-framed transaction of
//   phases CMD -> ADDR -> DUMMY -> WR(MOSI) -> RD(MISO), MSB first, SPI mode 0, single-line.
// - Oversamples the SPI pins on the system clock. Used as the bench-side responder and as a loopback
//   target in the SoC testbench. Reports each frame as cmd/addr/data with a valid or error pulse.
// PARAMETERS
// - CMD_MAX    32  max command bits captured
// - ADDR_MAX   32  max address bits captured
// - DATA_MAX   32  max WR / RD data bits
// - SYNC_STAGES 2  synchroniser depth for sclk/csn/mosi (>=2)
// PORTS
// - clk          in   1          system clock; must be >= 8x spi_sclk frequency
// - rstn         in   1          asynchronous active-low reset
// - spi_sclk     in   1          SPI clock from master, CPOL=0
// - spi_csn      in   1          chip select, active low
// - spi_mosi     in   1          master-out data
// - spi_miso     out  1          slave-out data
// - spi_miso_oe  out  1          1 while in RD phase
// - cfg_cmd_len  in   6          CMD bits (0 = skip phase)
// - cfg_addr_len in   6          ADDR bits (0 = skip)
// - cfg_dummy_len in  16         dummy sclk cycles (0 = skip)
// - cfg_wr_len   in   6          WR bits (0 = skip)
// - cfg_rd_len   in   6          RD bits (0 = skip)
// - rd_data      in   DATA_MAX   response word, right-aligned, sampled on RD entry
// - rx_cmd/rx_addr/rx_wr_data out CMD_MAX/ADDR_MAX/DATA_MAX  captured fields, right-aligned, upper 0
// - rx_valid     out  1          1-clk pulse: complete frame
// - rx_err       out  1          1-clk pulse: csn rose before all phases done
// - rx_bits      out  8          total sclk rising edges seen in last frame (saturates 255)
// - busy         out  1          1 from csn fall to csn rise
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; shift registers/counters 0.
// - Pins pass SYNC_STAGES flops; rise/fall of sclk and fall/rise of csn detected from last two stages.
// - csn fall: latch all cfg_* (lengths > MAX clipped to MAX), clear fields and rx_bits, busy=1,
//   enter first phase with non-zero length; if all zero, go DONE.
// - States: IDLE, CMD, ADDR, DUMMY, WR, RD, DONE. Each phase counts sclk rising edges down from its
//   length; on the edge that completes it, move to next non-zero phase (skip zeros), else DONE.
// - CMD/ADDR/WR: on sclk rise shift synced mosi into LSB of the field register.
// - DUMMY: sclk rises counted, mosi ignored.
// - RD: on entry load shift reg = rd_data << (DATA_MAX-rd_len), spi_miso_oe=1, spi_miso=shift MSB
//   (covers RD-first frames before first rise); each sclk fall shifts left, spi_miso=new MSB.
//   Outside RD: spi_miso=0, oe=0.
// - sclk edges while csn high ignored. Extra sclk rises in DONE: counted in rx_bits only.
// - csn rise: state DONE -> rx_valid pulse; any other non-IDLE state -> rx_err pulse (fields hold
//   partial data); both 2 sync stages + 1 clk after pin edge. busy=0, oe=0, return IDLE.
// - csn fall and rise in same clk impossible after sync; csn fall while not IDLE cannot occur.
// - Fields and rx_bits hold until next csn fall. Reset mid-frame: immediate return to reset values.
// STRUCTURE
// - Package pulpino_spi_slave_pkg: state enum spi_slv_state_e, CMD_MAX/ADDR_MAX/DATA_MAX defaults,
//   struct spi_slv_frame_s {cmd, addr, wr_data, bits} mirroring the bench collector packet.
// - Sub-module pulpino_spi_pin_sync: SYNC_STAGES synchroniser + rise/fall detect, instanced x3.
// TESTING
// - cmd=8,addr=24,dummy=8,wr=32,rd=0; send 0x02,0x001000,0xDEADBEEF -> one rx_valid, rx_cmd=0x02,
//   rx_addr=0x001000, rx_wr_data=0xDEADBEEF, rx_bits=72, rx_err=0.
// - cmd=8,addr=0,dummy=0,wr=0,rd=16,rd_data=0xA5C3; send 0x0B -> master samples 0xA5C3 on MISO,
//   oe high exactly during 16 RD bits, rx_valid pulse.
// - all lengths 0 except rd=8, rd_data=0x81 -> MISO=1 before first rise, master reads 0x81.
// - cmd=8,wr=32; raise csn after 20 bits -> rx_err pulse, rx_valid=0, rx_bits=20, rx_wr_data=0xFFF
//   for all-ones mosi.
// - cfg_wr_len=40 with DATA_MAX=32 -> clipped; valid after 32 WR bits; extra sclk only bumps rx_bits.
// - assert rstn mid-ADDR -> all outputs 0 same cycle; next full frame decodes correctly.

Source files
------------

// File: rtl/pulpino_spi_slave_pkg.sv
// Shared types and defaults for the PULPino SPI responder: FSM states, field widths,
// the frame record used by collectors, and the length-clipping helper.
package pulpino_spi_slave_pkg;

  localparam int unsigned SPI_CMD_MAX     = 32;
  localparam int unsigned SPI_ADDR_MAX    = 32;
  localparam int unsigned SPI_DATA_MAX    = 32;
  localparam int unsigned SPI_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DUMMY = 3'd3,
    ST_WR    = 3'd4,
    ST_RD    = 3'd5,
    ST_DONE  = 3'd6
  } spi_slv_state_e;

  typedef struct packed {
    logic [SPI_CMD_MAX-1:0]  cmd;
    logic [SPI_ADDR_MAX-1:0] addr;
    logic [SPI_DATA_MAX-1:0] wr_data;
    logic [7:0]              bits;
  } spi_slv_frame_s;

  function automatic logic [5:0] spi_clip_len(input logic [5:0] len, input int unsigned max_len);
    if (32'(len) > max_len) return 6'(max_len);
    return len;
  endfunction

endpackage

// File: rtl/pulpino_spi_pin_sync.sv
// Multi-stage synchroniser for one SPI pin, with single-cycle rise/fall strobes
// derived from the synchronised level and one extra history flop.
module pulpino_spi_pin_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic pin_i,
  output logic pin_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              last_q, last_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], pin_i};
    last_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      last_q <= last_d;
    end
  end

  assign pin_o  = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~last_q;
  assign fall_o = ~sync_q[STAGES-1] & last_q;

endmodule

// File: rtl/pulpino_spi_slave_rx.sv
// SPI mode-0 responder: decodes one CS-framed CMD/ADDR/DUMMY/WR/RD transaction from
// oversampled pins and reports the captured fields with a valid or error pulse.
module pulpino_spi_slave_rx
  import pulpino_spi_slave_pkg::*;
#(
  parameter int unsigned CMD_MAX     = SPI_CMD_MAX,
  parameter int unsigned ADDR_MAX    = SPI_ADDR_MAX,
  parameter int unsigned DATA_MAX    = SPI_DATA_MAX,
  parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                spi_sclk,
  input  logic                spi_csn,
  input  logic                spi_mosi,
  output logic                spi_miso,
  output logic                spi_miso_oe,
  input  logic [5:0]          cfg_cmd_len,
  input  logic [5:0]          cfg_addr_len,
  input  logic [15:0]         cfg_dummy_len,
  input  logic [5:0]          cfg_wr_len,
  input  logic [5:0]          cfg_rd_len,
  input  logic [DATA_MAX-1:0] rd_data,
  output logic [CMD_MAX-1:0]  rx_cmd,
  output logic [ADDR_MAX-1:0] rx_addr,
  output logic [DATA_MAX-1:0] rx_wr_data,
  output logic                rx_valid,
  output logic                rx_err,
  output logic [7:0]          rx_bits,
  output logic                busy
);

  logic sclk_s, sclk_rise, sclk_fall;
  logic csn_s, csn_rise, csn_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  pulpino_spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rstn(rstn), .pin_i(spi_sclk), .pin_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  pulpino_spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_csn (
    .clk(clk), .rstn(rstn), .pin_i(spi_csn), .pin_o(csn_s), .rise_o(csn_rise), .fall_o(csn_fall)
  );
  pulpino_spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rstn(rstn), .pin_i(spi_mosi), .pin_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_s, mosi_rise, mosi_fall};

  spi_slv_state_e      state_q, state_d, next_state;
  logic                enter_phase;
  logic [5:0]          cmd_len_q, cmd_len_d, addr_len_q, addr_len_d;
  logic [5:0]          wr_len_q, wr_len_d, rd_len_q, rd_len_d;
  logic [15:0]         dummy_len_q, dummy_len_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [CMD_MAX-1:0]  cmd_q, cmd_d;
  logic [ADDR_MAX-1:0] addr_q, addr_d;
  logic [DATA_MAX-1:0] wr_q, wr_d;
  logic [DATA_MAX-1:0] rd_shift_q, rd_shift_d;
  logic [7:0]          bits_q, bits_d;
  logic                busy_q, busy_d, valid_q, valid_d, err_q, err_d;
  logic [4:0]          phase_nz;

  function automatic spi_slv_state_e phase_after(input spi_slv_state_e from, input logic [4:0] nz);
    phase_after = ST_DONE;
    if (from < ST_RD    && nz[4]) phase_after = ST_RD;
    if (from < ST_WR    && nz[3]) phase_after = ST_WR;
    if (from < ST_DUMMY && nz[2]) phase_after = ST_DUMMY;
    if (from < ST_ADDR  && nz[1]) phase_after = ST_ADDR;
    if (from < ST_CMD   && nz[0]) phase_after = ST_CMD;
  endfunction

  // Lengths are captured at the start of a frame so cfg_* may change mid-transfer.
  always_comb begin
    cmd_len_d   = cmd_len_q;
    addr_len_d  = addr_len_q;
    dummy_len_d = dummy_len_q;
    wr_len_d    = wr_len_q;
    rd_len_d    = rd_len_q;
    if (state_q == ST_IDLE && csn_fall) begin
      cmd_len_d   = spi_clip_len(cfg_cmd_len, CMD_MAX);
      addr_len_d  = spi_clip_len(cfg_addr_len, ADDR_MAX);
      dummy_len_d = cfg_dummy_len;
      wr_len_d    = spi_clip_len(cfg_wr_len, DATA_MAX);
      rd_len_d    = spi_clip_len(cfg_rd_len, DATA_MAX);
    end
    phase_nz = {rd_len_d != 6'd0, wr_len_d != 6'd0, dummy_len_d != 16'd0,
                addr_len_d != 6'd0, cmd_len_d != 6'd0};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    rd_shift_d  = rd_shift_q;
    bits_d      = bits_q;
    busy_d      = busy_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    enter_phase = 1'b0;
    next_state  = ST_DONE;

    if (state_q == ST_IDLE) begin
      if (csn_fall) begin
        cmd_d       = '0;
        addr_d      = '0;
        wr_d        = '0;
        bits_d      = 8'd0;
        busy_d      = 1'b1;
        enter_phase = 1'b1;
        next_state  = phase_after(ST_IDLE, phase_nz);
      end
    end else if (csn_rise) begin
      valid_d = (state_q == ST_DONE);
      err_d   = (state_q != ST_DONE);
      busy_d  = 1'b0;
      state_d = ST_IDLE;
    end else if (!csn_s) begin
      if (sclk_rise) begin
        if (bits_q != 8'hFF) bits_d = bits_q + 8'd1;
        case (state_q)
          ST_CMD:  cmd_d  = {cmd_q[CMD_MAX-2:0], mosi_s};
          ST_ADDR: addr_d = {addr_q[ADDR_MAX-2:0], mosi_s};
          ST_WR:   wr_d   = {wr_q[DATA_MAX-2:0], mosi_s};
          default: ;
        endcase
        if (state_q != ST_DONE) begin
          if (cnt_q == 16'd1) begin
            enter_phase = 1'b1;
            next_state  = phase_after(state_q, phase_nz);
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
      end
      // The fall that follows RD entry precedes the first RD bit and must not shift.
      if (sclk_fall && state_q == ST_RD && cnt_q != {10'd0, rd_len_q})
        rd_shift_d = rd_shift_q << 1;
    end

    if (enter_phase) begin
      state_d = next_state;
      case (next_state)
        ST_CMD:   cnt_d = {10'd0, cmd_len_d};
        ST_ADDR:  cnt_d = {10'd0, addr_len_d};
        ST_DUMMY: cnt_d = dummy_len_d;
        ST_WR:    cnt_d = {10'd0, wr_len_d};
        ST_RD:    cnt_d = {10'd0, rd_len_d};
        default:  cnt_d = 16'd0;
      endcase
      if (next_state == ST_RD)
        rd_shift_d = rd_data << (DATA_MAX - 32'(rd_len_d));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cmd_len_q   <= 6'd0;
      addr_len_q  <= 6'd0;
      dummy_len_q <= 16'd0;
      wr_len_q    <= 6'd0;
      rd_len_q    <= 6'd0;
      cnt_q       <= 16'd0;
      cmd_q       <= '0;
      addr_q      <= '0;
      wr_q        <= '0;
      rd_shift_q  <= '0;
      bits_q      <= 8'd0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_len_q   <= cmd_len_d;
      addr_len_q  <= addr_len_d;
      dummy_len_q <= dummy_len_d;
      wr_len_q    <= wr_len_d;
      rd_len_q    <= rd_len_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      rd_shift_q  <= rd_shift_d;
      bits_q      <= bits_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign spi_miso_oe = (state_q == ST_RD);
  assign spi_miso    = (state_q == ST_RD) & rd_shift_q[DATA_MAX-1];
  assign rx_cmd      = cmd_q;
  assign rx_addr     = addr_q;
  assign rx_wr_data  = wr_q;
  assign rx_bits     = bits_q;
  assign rx_valid    = valid_q;
  assign rx_err      = err_q;
  assign busy        = busy_q;

endmodule
